// File: rtl/win_line_buf_if.sv
// win_line_buf_if: pixel stream in, window column stream out, plus frame
// control and status for the win_line_buf line buffer.
// master = upstream pixel source / downstream sink side, slave = line buffer.
interface win_line_buf_if #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int WIN_SIZE    = 3,
  parameter int CH_NUM      = 3
) ();
  localparam int RW = $clog2(FRAME_H_MAX - 1) + 1;
  localparam int CW = $clog2(FRAME_W_MAX - 1) + 1;

  logic [RW-1:0]                                  frame_h;
  logic [CW-1:0]                                  frame_w;
  logic                                           fin_start;
  logic                                           din_vld;
  logic                                           din_rdy;
  logic [CH_NUM-1:0][DIN_WIDTH-1:0]               din;
  logic                                           fout_start;
  logic                                           dout_vld;
  logic [WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] dout;
  logic                                           err;

  modport master (
    output frame_h, frame_w, fin_start, din_vld, din,
    input  din_rdy, fout_start, dout_vld, dout, err
  );

  modport slave (
    input  frame_h, frame_w, fin_start, din_vld, din,
    output din_rdy, fout_start, dout_vld, dout, err
  );
endinterface

// File: rtl/win_line_buf.sv
// win_line_buf: raster line buffer producing WIN_SIZE-tall pixel columns for
// the padded window generator. Output is held back while the first WIN_R rows
// fill, then WIN_R zero rows are flushed so each frame yields frame_h rows.
// Optional feature macro: WIN_LINE_BUF_CHECK_EN builds the sticky err flag
// and frame-size checks; without it err is tied low.
module win_line_buf #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int WIN_SIZE    = 3,
  parameter int CH_NUM      = 3
) (
  input logic           clk,
  input logic           reset_n,
  win_line_buf_if.slave io_bus
);
  localparam int WIN_R   = WIN_SIZE / 2;
  localparam int NUM_MEM = WIN_SIZE - 1;
  localparam int PW      = CH_NUM * DIN_WIDTH;
  localparam int RW      = $clog2(FRAME_H_MAX - 1) + 1;
  localparam int CW      = $clog2(FRAME_W_MAX - 1) + 1;
  localparam int AW      = (FRAME_W_MAX > 1) ? $clog2(FRAME_W_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CW-1:0]               r_col_cnt;
  logic [RW-1:0]               r_row_cnt;
  logic [RW-1:0]               r_frame_h;
  logic [CW-1:0]               r_frame_w;
  logic                        r_fout_start;
  logic                        r_dout_vld;
  logic [WIN_SIZE-1:0][PW-1:0] r_dout;
  logic                        r_wr_en;
  logic [AW-1:0]               r_wr_addr;
  logic [PW-1:0]               r_mem [NUM_MEM][FRAME_W_MAX];

  logic                        w_din_rdy;
  logic                        w_accept;
  logic                        w_flush_gen;
  logic                        w_step;
  logic                        w_col_end;
  logic                        w_size_ok;
  logic [AW-1:0]               w_addr;

  assign w_step    = w_accept | w_flush_gen;
  assign w_col_end = (r_col_cnt == (r_frame_w - CW'(1)));
  assign w_addr    = r_col_cnt[AW-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state: fin_start aborts from anywhere; row ends drive the phases.
  always_comb begin
    w_state_next = r_state;
    if (io_bus.fin_start) begin
      w_state_next = w_size_ok ? S_FILL : S_IDLE;
    end else begin
      case (r_state)
        S_FILL:   if (w_step && w_col_end && (r_row_cnt == RW'(WIN_R - 1)))
                    w_state_next = S_STREAM;
        S_STREAM: if (w_step && w_col_end && (r_row_cnt == (r_frame_h - RW'(1))))
                    w_state_next = S_FLUSH;
        S_FLUSH:  if (w_step && w_col_end && (r_row_cnt == RW'(WIN_R - 1)))
                    w_state_next = S_IDLE;
        default:  w_state_next = r_state;
      endcase
    end
  end

  // Per-state outputs: ready, pixel accept and flush column generation.
  always_comb begin
    w_din_rdy   = 1'b0;
    w_accept    = 1'b0;
    w_flush_gen = 1'b0;
    case (r_state)
      S_FILL, S_STREAM: begin
        w_din_rdy = 1'b1;
        w_accept  = io_bus.din_vld & ~io_bus.fin_start;
      end
      S_FLUSH: w_flush_gen = ~io_bus.fin_start;
      default: ;
    endcase
  end

  // Frame size capture on frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_h <= '0;
      r_frame_w <= '0;
    end else if (io_bus.fin_start) begin
      r_frame_h <= io_bus.frame_h;
      r_frame_w <= io_bus.frame_w;
    end
  end

  // Column/row counters; row restarts at 0 when FLUSH begins so the flush
  // length is simply WIN_R rows of frame_w columns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (io_bus.fin_start || (r_state == S_IDLE)) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_step) begin
      if (w_col_end) begin
        r_col_cnt <= '0;
        if ((r_state == S_STREAM) && (r_row_cnt == (r_frame_h - RW'(1))))
          r_row_cnt <= '0;
        else
          r_row_cnt <= r_row_cnt + RW'(1);
      end else begin
        r_col_cnt <= r_col_cnt + CW'(1);
      end
    end
  end

  // Registered strobes: fout_start on the FILL->STREAM edge, dout_vld per column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fout_start <= 1'b0;
      r_dout_vld   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      r_fout_start <= (r_state == S_FILL) && (w_state_next == S_STREAM);
      r_dout_vld   <= w_flush_gen | (w_accept && (r_state == S_STREAM));
      r_wr_en      <= w_step;
      r_wr_addr    <= w_addr;
    end
  end

  // Column capture: newest row from din (zero while flushing), older rows from
  // a registered read of the line memories at the current column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else if (w_step) begin
      r_dout[0] <= w_flush_gen ? '0 : io_bus.din;
      for (int k = 1; k < WIN_SIZE; k++)
        r_dout[k] <= r_mem[k-1][w_addr];
    end
  end

  // Line memory write, one cycle after the read: the captured column is
  // exactly the shifted-down content (mem[0] <= newest, mem[k] <= old mem[k-1]).
  // The next read is always at a different column, so the delay is invisible.
  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      for (int k = 0; k < NUM_MEM; k++)
        r_mem[k][r_wr_addr] <= r_dout[k];
    end
  end

`ifdef WIN_LINE_BUF_CHECK_EN
  logic r_err;

  assign w_size_ok = (io_bus.frame_h >= RW'(WIN_SIZE))    &&
                     (io_bus.frame_h <= RW'(FRAME_H_MAX)) &&
                     (io_bus.frame_w >= CW'(2))           &&
                     (io_bus.frame_w <= CW'(FRAME_W_MAX));

  // Sticky protocol error; a new frame start re-evaluates it from the sizes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= 1'b0;
    else if (io_bus.fin_start)
      r_err <= ~w_size_ok;
    else if ((r_state != S_IDLE) && !w_din_rdy && io_bus.din_vld)
      r_err <= 1'b1;
  end

  assign io_bus.err = r_err;
`else
  assign w_size_ok  = 1'b1;
  assign io_bus.err = 1'b0;
`endif

  assign io_bus.din_rdy    = w_din_rdy;
  assign io_bus.fout_start = r_fout_start;
  assign io_bus.dout_vld   = r_dout_vld;
  assign io_bus.dout       = r_dout;

endmodule
